// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard control unit.
package hazard_pkg;

    typedef enum logic {
        IDLE       = 1'b0,
        LOAD_STALL = 1'b1
    } hz_state_e;

    localparam logic [4:0] ZERO_REG = 5'd0;

    localparam int LOAD_LAT_MIN = 1;
    localparam int LOAD_LAT_MAX = 4;

    function automatic bit load_latency_legal(input int lat);
        return (lat >= LOAD_LAT_MIN) && (lat <= LOAD_LAT_MAX);
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use stall, branch flush and memory-busy freeze control for the 5-stage pipe.
//
//   state      | meaning
//   IDLE       | no multi-cycle load stall in progress; hit bubbles combinationally
//   LOAD_STALL | issuing the remaining rem_q bubbles of a load-use hazard
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int LOAD_LATENCY    = 1,
    parameter int CNT_WIDTH       = 16,
    parameter bit ZERO_REG_FILTER = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ID_EX_MemRead_i,
    input  logic [REG_ADDR_WIDTH-1:0] ID_EX_Rt_i,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_Rs_i,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_Rt_i,
    input  logic                      IF_ID_UsesRt_i,
    input  logic                      EX_BranchTaken_i,
    input  logic                      DMem_Busy_i,
    input  logic                      clr_stats_i,
    output logic                      PCWrite_o,
    output logic                      IF_ID_Write_o,
    output logic                      sel_bubble_o,
    output logic                      IF_ID_Flush_o,
    output logic                      ID_EX_Flush_o,
    output logic                      Pipe_Hold_o,
    output logic [CNT_WIDTH-1:0]      stall_cycles_o
);

    generate
        if (!load_latency_legal(LOAD_LATENCY)) begin : g_bad_latency
            $error("hazard_ctrl_unit: LOAD_LATENCY must be within 1..4");
        end
    endgenerate

    localparam logic [1:0] REM_INIT = 2'(LOAD_LATENCY - 1);

    hz_state_e  state_q, state_d;
    logic [1:0] rem_q, rem_d;
    logic       is_zero_dst;
    logic       hit;

    assign is_zero_dst = ZERO_REG_FILTER && (ID_EX_Rt_i == REG_ADDR_WIDTH'(ZERO_REG));
    assign hit = ID_EX_MemRead_i && !is_zero_dst &&
                 ((ID_EX_Rt_i == IF_ID_Rs_i) ||
                  (IF_ID_UsesRt_i && (ID_EX_Rt_i == IF_ID_Rt_i)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rem_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (DMem_Busy_i) begin
            state_d = state_q;
            rem_d   = rem_q;
        end else if (EX_BranchTaken_i) begin
            // the dependent instruction is flushed, so any pending stall is moot
            state_d = IDLE;
            rem_d   = 2'd0;
        end else if (state_q == LOAD_STALL) begin
            rem_d = rem_q - 2'd1;
            if (rem_q == 2'd1) begin
                state_d = IDLE;
            end
        end else if (hit && (LOAD_LATENCY > 1)) begin
            state_d = LOAD_STALL;
            rem_d   = REM_INIT;
        end
    end

    always_comb begin
        PCWrite_o     = 1'b1;
        IF_ID_Write_o = 1'b1;
        sel_bubble_o  = 1'b0;
        IF_ID_Flush_o = 1'b0;
        ID_EX_Flush_o = 1'b0;
        Pipe_Hold_o   = 1'b0;
        if (DMem_Busy_i) begin
            PCWrite_o     = 1'b0;
            IF_ID_Write_o = 1'b0;
            Pipe_Hold_o   = 1'b1;
        end else if (EX_BranchTaken_i) begin
            IF_ID_Flush_o = 1'b1;
            ID_EX_Flush_o = 1'b1;
        end else if ((state_q == LOAD_STALL) || hit) begin
            PCWrite_o     = 1'b0;
            IF_ID_Write_o = 1'b0;
            sel_bubble_o  = 1'b1;
        end
    end

    sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_stall_cnt (
        .clk    (clk),
        .rst_n  (reset),
        .en_i   (!PCWrite_o),
        .clr_i  (clr_stats_i),
        .count_o(stall_cycles_o)
    );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench: one instance with LOAD_LATENCY=1 and one with LOAD_LATENCY=3 on shared stimulus.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       mr, uses_rt, br, busy, clr;
    logic [4:0] ex_rt, rs, rt;

    logic        pcw1, ifw1, bub1, iff1, exf1, hold1;
    logic        pcw3, ifw3, bub3, iff3, exf3, hold3;
    logic [15:0] cnt1, cnt3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.LOAD_LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset),
        .ID_EX_MemRead_i(mr), .ID_EX_Rt_i(ex_rt), .IF_ID_Rs_i(rs), .IF_ID_Rt_i(rt),
        .IF_ID_UsesRt_i(uses_rt), .EX_BranchTaken_i(br), .DMem_Busy_i(busy), .clr_stats_i(clr),
        .PCWrite_o(pcw1), .IF_ID_Write_o(ifw1), .sel_bubble_o(bub1),
        .IF_ID_Flush_o(iff1), .ID_EX_Flush_o(exf1), .Pipe_Hold_o(hold1), .stall_cycles_o(cnt1)
    );

    hazard_ctrl_unit #(.LOAD_LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset),
        .ID_EX_MemRead_i(mr), .ID_EX_Rt_i(ex_rt), .IF_ID_Rs_i(rs), .IF_ID_Rt_i(rt),
        .IF_ID_UsesRt_i(uses_rt), .EX_BranchTaken_i(br), .DMem_Busy_i(busy), .clr_stats_i(clr),
        .PCWrite_o(pcw3), .IF_ID_Write_o(ifw3), .sel_bubble_o(bub3),
        .IF_ID_Flush_o(iff3), .ID_EX_Flush_o(exf3), .Pipe_Hold_o(hold3), .stall_cycles_o(cnt3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mr = 0; uses_rt = 0; br = 0; busy = 0; clr = 0;
        ex_rt = 5'd1; rs = 5'd2; rt = 5'd3;
    endtask

    task automatic clear_and_settle();
        idle_inputs();
        for (int i = 0; i < 4; i++) tick();
        clr = 1; tick(); clr = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        #12;
        checks++;
        if ({pcw1, ifw1, bub1, iff1, exf1, hold1} !== 6'b110000) begin
            errors++; $display("FAIL reset_out_l1 got %b exp 110000", {pcw1, ifw1, bub1, iff1, exf1, hold1});
        end
        checks++;
        if (cnt1 !== 16'd0 || cnt3 !== 16'd0) begin
            errors++; $display("FAIL reset_cnt got %h/%h exp 0000/0000", cnt1, cnt3);
        end
        reset = 1;
        tick();
    endtask

    task automatic test_lat1();
        clear_and_settle();
        mr = 1; ex_rt = 5'd8; rs = 5'd8; #1;
        checks++;
        if ({pcw1, ifw1, bub1} !== 3'b001) begin
            errors++; $display("FAIL lat1_bubble got %b exp 001", {pcw1, ifw1, bub1});
        end
        tick();
        idle_inputs(); #1;
        checks++;
        if ({pcw1, ifw1, bub1} !== 3'b110) begin
            errors++; $display("FAIL lat1_after got %b exp 110", {pcw1, ifw1, bub1});
        end
        checks++;
        if (cnt1 !== 16'd1) begin
            errors++; $display("FAIL lat1_cnt got %0d exp 1", cnt1);
        end
    endtask

    task automatic test_lat3_rt();
        logic [2:0] seen;
        clear_and_settle();
        mr = 1; ex_rt = 5'd9; rs = 5'd3; rt = 5'd9; uses_rt = 1; #1;
        seen[0] = bub3 & ~pcw3 & ~ifw3;
        tick();
        idle_inputs(); #1;
        seen[1] = bub3 & ~pcw3 & ~ifw3;
        tick(); #1;
        seen[2] = bub3 & ~pcw3 & ~ifw3;
        checks++;
        if (seen !== 3'b111) begin
            errors++; $display("FAIL lat3_bubbles got %b exp 111", seen);
        end
        tick(); #1;
        checks++;
        if ({pcw3, ifw3, bub3} !== 3'b110) begin
            errors++; $display("FAIL lat3_after got %b exp 110", {pcw3, ifw3, bub3});
        end
        checks++;
        if (cnt3 !== 16'd3) begin
            errors++; $display("FAIL lat3_cnt got %0d exp 3", cnt3);
        end
    endtask

    task automatic test_zero_filter();
        clear_and_settle();
        mr = 1; ex_rt = 5'd0; rs = 5'd0; #1;
        checks++;
        if ({pcw1, pcw3} !== 2'b11) begin
            errors++; $display("FAIL zero_reg got pcw %b exp 11", {pcw1, pcw3});
        end
        ex_rt = 5'd5; rt = 5'd5; rs = 5'd6; uses_rt = 0; #1;
        checks++;
        if ({pcw1, pcw3} !== 2'b11) begin
            errors++; $display("FAIL rt_unused got pcw %b exp 11", {pcw1, pcw3});
        end
        uses_rt = 1; #1;
        checks++;
        if ({pcw1, bub1} !== 2'b01) begin
            errors++; $display("FAIL rt_used got pcw,bub %b exp 01", {pcw1, bub1});
        end
        idle_inputs();
    endtask

    task automatic test_branch();
        clear_and_settle();
        mr = 1; ex_rt = 5'd7; rs = 5'd7; #1;
        tick();
        idle_inputs(); br = 1; #1;
        checks++;
        if ({iff3, exf3, pcw3, bub3} !== 4'b1110) begin
            errors++; $display("FAIL branch_flush got %b exp 1110", {iff3, exf3, pcw3, bub3});
        end
        tick();
        br = 0; #1;
        checks++;
        if ({pcw3, bub3, iff3, exf3} !== 4'b1000) begin
            errors++; $display("FAIL branch_next got %b exp 1000", {pcw3, bub3, iff3, exf3});
        end
        tick(); #1;
        checks++;
        if ({pcw3, bub3} !== 2'b10 || cnt3 !== 16'd1) begin
            errors++; $display("FAIL branch_abort got pcw,bub %b cnt %0d exp 10 cnt 1", {pcw3, bub3}, cnt3);
        end
    endtask

    task automatic test_busy_freeze();
        int bad;
        clear_and_settle();
        mr = 1; ex_rt = 5'd4; rs = 5'd4; #1;
        tick();
        idle_inputs(); busy = 1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if ({hold3, bub3, pcw3, ifw3} !== 4'b1000) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL busy_hold bad_cycles %0d exp 0", bad);
        end
        busy = 0;
        bad = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            if ({hold3, bub3, pcw3} !== 3'b010) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL busy_resume bad_cycles %0d exp 0", bad);
        end
        #1;
        checks++;
        if ({pcw3, bub3} !== 2'b10 || cnt3 !== 16'd7) begin
            errors++; $display("FAIL busy_cnt got pcw,bub %b cnt %0d exp 10 cnt 7", {pcw3, bub3}, cnt3);
        end
    endtask

    task automatic test_saturate();
        clear_and_settle();
        busy = 1;
        for (int i = 0; i < 65534; i++) tick();
        busy = 0; #1;
        checks++;
        if (cnt3 !== 16'hFFFE) begin
            errors++; $display("FAIL sat_pre got %h exp fffe", cnt3);
        end
        busy = 1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (cnt3 !== 16'hFFFF) begin
            errors++; $display("FAIL sat_hold got %h exp ffff", cnt3);
        end
        clr = 1; tick();
        checks++;
        if (cnt3 !== 16'd0) begin
            errors++; $display("FAIL clr_vs_inc got %h exp 0000", cnt3);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_stall();
        clear_and_settle();
        mr = 1; ex_rt = 5'd10; rs = 5'd10; #1;
        tick();
        idle_inputs(); #1;
        checks++;
        if ({pcw3, bub3} !== 2'b01) begin
            errors++; $display("FAIL mid_stall_pre got %b exp 01", {pcw3, bub3});
        end
        #2;
        reset = 0; #1;
        checks++;
        if ({pcw3, ifw3, bub3, hold3} !== 4'b1100 || cnt3 !== 16'd0) begin
            errors++; $display("FAIL async_reset got %b cnt %0d exp 1100 cnt 0", {pcw3, ifw3, bub3, hold3}, cnt3);
        end
        #1;
        reset = 1;
        tick(); #1;
        checks++;
        if ({pcw3, bub3} !== 2'b10) begin
            errors++; $display("FAIL post_reset got %b exp 10", {pcw3, bub3});
        end
    endtask

    initial begin
        test_reset();
        test_lat1();
        test_lat3_rt();
        test_zero_filter();
        test_branch();
        test_busy_freeze();
        test_saturate();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised successor to the pipeline Hazard Detection Unit for the 5-stage MIPS core. It detects load-use hazards, with a configurable load latency and an optional rt-use qualifier and $zero filter. It also handles branch/jump flushes from EX, freezes the whole pipe while data memory is busy, and keeps a saturating stall-cycle performance counter. It sits beside the IF/ID and ID/EX registers and drives the PC enable, the IF/ID enable, the control-bubble mux select and the flush/hold lines.

Parameters:
REG_ADDR_WIDTH, 5, register specifier width.
LOAD_LATENCY, 1, total bubble cycles per load-use hazard (legal 1..4).
CNT_WIDTH, 16, width of the stall-cycle counter.
ZERO_REG_FILTER, 1, when 1 a destination of register 0 never causes a hazard.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
ID_EX_MemRead_i  in  1  instruction in EX is a load.
ID_EX_Rt_i  in  REG_ADDR_WIDTH  load destination register (rt) in EX.
IF_ID_Rs_i  in  REG_ADDR_WIDTH  rs of the instruction in ID.
IF_ID_Rt_i  in  REG_ADDR_WIDTH  rt of the instruction in ID.
IF_ID_UsesRt_i  in  1  the instruction in ID reads rt as a source.
EX_BranchTaken_i  in  1  taken branch or jump resolved in EX.
DMem_Busy_i  in  1  data memory not ready; the pipe must freeze.
clr_stats_i  in  1  synchronous clear of the stall counter.
PCWrite_o  out  1  PC enable.
IF_ID_Write_o  out  1  IF/ID register enable.
sel_bubble_o  out  1  force the ID/EX control fields to 0.
IF_ID_Flush_o  out  1  clear IF/ID on the next edge.
ID_EX_Flush_o  out  1  clear ID/EX on the next edge.
Pipe_Hold_o  out  1  hold ID/EX, EX/MEM and MEM/WB.
stall_cycles_o  out  CNT_WIDTH  saturating count of cycles with PCWrite_o=0.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low.
- Reset state: FSM in IDLE, remaining counter rem=0, stall_cycles_o=0.
- Output defaults: PCWrite_o=1, IF_ID_Write_o=1, all other outputs 0.
- hit (combinational) = ID_EX_MemRead_i AND NOT(ZERO_REG_FILTER AND ID_EX_Rt_i==0) AND (ID_EX_Rt_i==IF_ID_Rs_i OR (IF_ID_UsesRt_i AND ID_EX_Rt_i==IF_ID_Rt_i)).
- All outputs are combinational from the current state and inputs, with zero latency. The first bubble is issued in the same cycle as hit.
- FSM states are IDLE and LOAD_STALL. rem is a 2-bit down-counter.
- Priority per cycle, highest first:
  1) DMem_Busy_i=1: PCWrite_o=0, IF_ID_Write_o=0, Pipe_Hold_o=1, sel_bubble_o=0, no flush. State and rem are frozen. A pending branch is acted on when busy drops, because EX is held.
  2) EX_BranchTaken_i=1: IF_ID_Flush_o=1, ID_EX_Flush_o=1, PCWrite_o=1, sel_bubble_o=0. Next state is IDLE and rem=0, which aborts any load stall because the dependent instruction is flushed.
  3) State is LOAD_STALL: PCWrite_o=0, IF_ID_Write_o=0, sel_bubble_o=1. rem decrements. When rem==1, next state is IDLE.
  4) State is IDLE and hit=1: PCWrite_o=0, IF_ID_Write_o=0, sel_bubble_o=1.
     - If LOAD_LATENCY>1: go to LOAD_STALL with rem=LOAD_LATENCY-1.
     - If LOAD_LATENCY==1: stay in IDLE. The hazard clears naturally once the load leaves EX.
  5) Otherwise: defaults.
- Each load-use hazard produces exactly LOAD_LATENCY bubble cycles, excluding busy-frozen cycles.
- In LOAD_STALL, hit is ignored.
- Counter: stall_cycles_o increments by 1 on each edge where PCWrite_o==0 (busy or load stall). It saturates at all-ones. clr_stats_i has priority over increment; if both occur in the same cycle the result is 0.
- Reset asserted mid-stall: outputs return to the defaults immediately (asynchronously).

Decomposition:
- Shared package hazard_pkg:
  - FSM state typedef (IDLE, LOAD_STALL).
  - ZERO_REG constant (5'd0).
  - Legal LOAD_LATENCY bounds, with a static check enforcing 1..4.
- One natural sub-module: sat_counter (CNT_WIDTH, enable, synchronous clear, saturate). It is reusable for other performance counters.

Test Plan:
- LOAD_LATENCY=1; MemRead=1, ID_EX_Rt=8, IF_ID_Rs=8 for 1 cycle -> PCWrite=0, IF_ID_Write=0, sel_bubble=1 that cycle only; stall_cycles_o=1.
- LOAD_LATENCY=3; hit on Rt=9 with UsesRt=1, then inputs dropped -> exactly 3 consecutive bubble cycles, then defaults; stall_cycles_o=3.
- ID_EX_Rt=0 with Rs=0 and MemRead=1, ZERO_REG_FILTER=1 -> no stall. Same case with UsesRt=0, Rt match only, Rs mismatch -> no stall.
- LOAD_LATENCY=3; branch taken in the 2nd stall cycle -> both flushes=1, PCWrite=1 that cycle; next cycle IDLE, no further bubbles.
- DMem_Busy=1 for 4 cycles during LOAD_STALL with rem=2 -> Pipe_Hold=1, sel_bubble=0 for 4 cycles; afterwards 2 more bubble cycles; counter +6.
- Counter set to 0xFFFE (CNT_WIDTH=16), 3 stall cycles -> holds at 0xFFFF. clr_stats with a stall in the same cycle -> 0. Reset asserted mid-stall -> outputs at defaults with no clock edge.
